// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 scancode constants, prefix-state enum and key decode helpers.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} pfx_t;
    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_M     = 8'h3A;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Returns {hit, bcd digit}
    function automatic logic [4:0] digit_of(input logic [7:0] sc);
        case (sc)
            8'h45: return 5'h10;
            8'h16: return 5'h11;
            8'h1E: return 5'h12;
            8'h26: return 5'h13;
            8'h25: return 5'h14;
            8'h2E: return 5'h15;
            8'h36: return 5'h16;
            8'h3D: return 5'h17;
            8'h3E: return 5'h18;
            8'h46: return 5'h19;
            default: return 5'h00;
        endcase
    endfunction

    function automatic dir_t arrow_of(input logic [7:0] sc);
        return sc == SC_UP ? DIR_UP : sc == SC_DOWN ? DIR_DOWN :
               sc == SC_LEFT ? DIR_LEFT : sc == SC_RIGHT ? DIR_RIGHT : DIR_NONE;
    endfunction
endpackage

// File: rtl/ps2_cmd_decoder_if.sv
// ps2_cmd_decoder_if: scancode byte stream from the PS/2 receiver.
interface ps2_cmd_decoder_if;
    logic [7:0] scancode;
    logic       scancode_valid;
    modport master (output scancode, scancode_valid);
    modport slave  (input scancode, scancode_valid);
endinterface

// File: rtl/key_repeat_timer.sv
// key_repeat_timer: typematic timer, strobes rep DELAY cycles after restart then every PERIOD cycles while hold.
module key_repeat_timer #(
    parameter int DELAY  = 16,
    parameter int PERIOD = 4
) (
    input  logic clk_in,
    input  logic reset,
    input  logic hold,
    input  logic restart,
    output logic rep
);
    localparam int CW = $clog2((DELAY > PERIOD ? DELAY : PERIOD) + 1);
    logic [CW-1:0] cnt;
    logic          first;
    assign rep = hold && !restart && cnt == (first ? CW'(DELAY) : CW'(PERIOD));
    always_ff @(posedge clk_in or posedge reset)
        if (reset) begin
            cnt   <= '0;
            first <= 1'b0;
        end else if (restart) begin
            cnt   <= CW'(1);
            first <= 1'b1;
        end else if (rep) begin
            cnt   <= CW'(1);
            first <= 1'b0;
        end else if (hold) cnt <= cnt + CW'(1);
endmodule

// File: rtl/ps2_cmd_decoder.sv
// ps2_cmd_decoder: PS/2 scancodes to run-control pulses, BCD file-id entry and a grid cursor
// with arrow-key auto-repeat.
module ps2_cmd_decoder
    import ps2_pkg::*;
#(
    parameter int GRID_N        = 64,
    parameter int GRID_M        = 48,
    parameter int WIDTH         = 12,
    parameter int DIGITS        = 3,
    parameter int PULSE_CYCLES  = 4,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4,
    parameter int CURSOR_WRAP   = 0
) (
    input  logic                clk_in,
    input  logic                reset,
    ps2_cmd_decoder_if.slave    kb,
    output logic                start,
    output logic                pause,
    output logic                clear,
    output logic                running,
    output logic                manual,
    output logic [4*DIGITS-1:0] file_id,
    output logic                file_id_load,
    output logic [4*DIGITS-1:0] entry_bcd,
    output logic [WIDTH-1:0]    cursor_x,
    output logic [WIDTH-1:0]    cursor_y,
    output logic [2*WIDTH-1:0]  cursor_pos,
    output logic                toggle
);
    localparam int DW = 4 * DIGITS;
    localparam int PW = 2 * WIDTH;
    localparam int PC = $clog2(PULSE_CYCLES + 1);
    localparam logic [WIDTH-1:0] CX   = WIDTH'(GRID_N / 2);
    localparam logic [WIDTH-1:0] CY   = WIDTH'(GRID_M / 2);
    localparam logic [WIDTH-1:0] XMAX = WIDTH'(GRID_N - 1);
    localparam logic [WIDTH-1:0] YMAX = WIDTH'(GRID_M - 1);
    localparam logic [PW-1:0]    CPOS = PW'(CY) * PW'(GRID_N) + PW'(CX);

    pfx_t            state;
    dir_t            held, arr, mv;
    logic [PC-1:0]   pulse_cnt;
    logic [4:0]      dig;
    logic            key_ev, mk, brk, enter_go, p_go, r_go, m_go, space_go, dig_go, bksp_go;
    logic            arrow_go, stop, rep, cmd;
    logic [WIDTH-1:0] x_dec, x_inc, y_dec, y_inc, nx, ny;

    assign key_ev   = kb.scancode_valid && kb.scancode != SC_EXT && kb.scancode != SC_BRK;
    assign mk       = key_ev && (state == IDLE || state == EXT);
    assign brk      = key_ev && (state == BRK || state == EXT_BRK);
    assign dig      = digit_of(kb.scancode);
    assign arr      = (state == EXT || state == EXT_BRK) ? arrow_of(kb.scancode) : DIR_NONE;
    assign enter_go = mk && kb.scancode == SC_ENTER && !running;
    assign p_go     = mk && kb.scancode == SC_P && running;
    assign r_go     = mk && kb.scancode == SC_R;
    assign m_go     = mk && kb.scancode == SC_M && !running;
    assign space_go = mk && kb.scancode == SC_SPACE && manual;
    assign dig_go   = mk && dig[4];
    assign bksp_go  = mk && kb.scancode == SC_BKSP;
    // A typematic make of the already-held arrow is deliberately not a new arrow
    assign arrow_go = mk && manual && arr != DIR_NONE && arr != held;
    assign stop     = brk && arr != DIR_NONE && arr == held;
    assign cmd      = enter_go || p_go || r_go;
    assign mv       = arrow_go ? arr : (rep && manual) ? held : DIR_NONE;

    key_repeat_timer #(.DELAY(REPEAT_DELAY), .PERIOD(REPEAT_PERIOD)) u_rep (
        .clk_in  (clk_in),
        .reset   (reset),
        .hold    (held != DIR_NONE && !stop),
        .restart (arrow_go),
        .rep     (rep)
    );

    assign x_dec = cursor_x == '0 ? (CURSOR_WRAP != 0 ? XMAX : '0) : cursor_x - WIDTH'(1);
    assign x_inc = cursor_x == XMAX ? (CURSOR_WRAP != 0 ? '0 : XMAX) : cursor_x + WIDTH'(1);
    assign y_dec = cursor_y == '0 ? (CURSOR_WRAP != 0 ? YMAX : '0) : cursor_y - WIDTH'(1);
    assign y_inc = cursor_y == YMAX ? (CURSOR_WRAP != 0 ? '0 : YMAX) : cursor_y + WIDTH'(1);
    assign nx = enter_go ? CX : mv == DIR_LEFT ? x_dec : mv == DIR_RIGHT ? x_inc : cursor_x;
    assign ny = enter_go ? CY : mv == DIR_UP ? y_dec : mv == DIR_DOWN ? y_inc : cursor_y;

    always_ff @(posedge clk_in or posedge reset)
        if (reset) begin
            state        <= IDLE;
            held         <= DIR_NONE;
            pulse_cnt    <= '0;
            {start, pause, clear, running, manual, file_id_load, toggle} <= '0;
            file_id      <= '0;
            entry_bcd    <= '0;
            cursor_x     <= CX;
            cursor_y     <= CY;
            cursor_pos   <= CPOS;
        end else begin
            if (kb.scancode_valid)
                state <= (kb.scancode == SC_EXT && state == IDLE) ? EXT :
                         (kb.scancode == SC_BRK && state == IDLE) ? BRK :
                         (kb.scancode == SC_BRK && state == EXT) ? EXT_BRK : IDLE;
            file_id_load <= enter_go;
            toggle       <= space_go;
            if (enter_go) file_id <= entry_bcd;
            if (cmd) begin
                start     <= enter_go;
                pause     <= p_go;
                clear     <= r_go;
                pulse_cnt <= PC'(PULSE_CYCLES - 1);
            end else if (pulse_cnt == '0) {start, pause, clear} <= '0;
            else pulse_cnt <= pulse_cnt - PC'(1);
            if (enter_go) begin
                running <= 1'b1;
                manual  <= 1'b0;
            end else if (p_go) running <= 1'b0;
            else if (r_go) begin
                running <= 1'b0;
                manual  <= 1'b0;
            end else if (m_go) manual <= !manual;
            if (r_go) entry_bcd <= '0;
            else if (dig_go) entry_bcd <= (entry_bcd << 4) | DW'(dig[3:0]);
            else if (bksp_go) entry_bcd <= entry_bcd >> 4;
            if (arrow_go) held <= arr;
            else if (stop) held <= DIR_NONE;
            cursor_x   <= nx;
            cursor_y   <= ny;
            cursor_pos <= PW'(ny) * PW'(GRID_N) + PW'(nx);
        end
endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// tb_ps2_cmd_decoder: directed and random scancode streams into clamp and wrap instances,
// checked every cycle against a time-based reference model.
module tb_ps2_cmd_decoder;
    logic clk_in = 1'b0;
    logic reset;
    always #5 clk_in = ~clk_in;

    ps2_cmd_decoder_if kb();

    logic a_start, a_pause, a_clear, a_running, a_manual, a_load, a_toggle;
    logic b_start, b_pause, b_clear, b_running, b_manual, b_load, b_toggle;
    logic [11:0] a_file, a_entry, a_x, a_y, b_file, b_entry, b_x, b_y;
    logic [23:0] a_pos, b_pos;

    ps2_cmd_decoder #(.CURSOR_WRAP(0)) dut_clamp (
        .clk_in(clk_in), .reset(reset), .kb(kb), .start(a_start), .pause(a_pause), .clear(a_clear),
        .running(a_running), .manual(a_manual), .file_id(a_file), .file_id_load(a_load),
        .entry_bcd(a_entry), .cursor_x(a_x), .cursor_y(a_y), .cursor_pos(a_pos), .toggle(a_toggle));
    ps2_cmd_decoder #(.CURSOR_WRAP(1)) dut_wrap (
        .clk_in(clk_in), .reset(reset), .kb(kb), .start(b_start), .pause(b_pause), .clear(b_clear),
        .running(b_running), .manual(b_manual), .file_id(b_file), .file_id_load(b_load),
        .entry_bcd(b_entry), .cursor_x(b_x), .cursor_y(b_y), .cursor_pos(b_pos), .toggle(b_toggle));

    int n_run, n_fail, cyc;
    bit m_ext, m_brk, m_running, m_manual, m_load, m_toggle;
    int m_entry, m_file, m_cmd, m_cmd_t, m_hold_t, m_x0, m_y0, m_x1, m_y1;
    logic [7:0] m_held;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int digit_val(input logic [7:0] sc);
        logic [7:0] codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 10; i++) if (codes[i] == sc) return i;
        return -1;
    endfunction

    function automatic int step(input int v, input int d, input int mx, input bit wrap);
        int t = v + d;
        if (t < 0) return wrap ? mx : 0;
        if (t > mx) return wrap ? 0 : mx;
        return t;
    endfunction

    task automatic model_reset();
        {m_ext, m_brk, m_running, m_manual, m_load, m_toggle} = '0;
        m_entry = 0; m_file = 0; m_cmd = 0; m_held = 8'h00;
        m_x0 = 32; m_y0 = 24; m_x1 = 32; m_y1 = 24;
    endtask

    task automatic model_step(input bit v, input logic [7:0] sc);
        bit dec, mk, new_arrow, stop, fire, go_enter, go_p, go_r, go_m;
        logic [7:0] arr, mv;
        int k, d, dx, dy;
        cyc++;
        dec = v && sc != 8'hE0 && sc != 8'hF0;
        mk = dec && !m_brk;
        arr = (dec && m_ext && (sc == 8'h75 || sc == 8'h72 || sc == 8'h6B || sc == 8'h74)) ? sc : 8'h00;
        new_arrow = mk && arr != 0 && m_manual && arr != m_held;
        stop = dec && m_brk && arr != 0 && arr == m_held;
        k = cyc - m_hold_t;
        fire = m_held != 0 && !stop && !new_arrow && k >= 16 && (k - 16) % 4 == 0;
        mv = new_arrow ? arr : (fire && m_manual) ? m_held : 8'h00;
        go_enter = mk && sc == 8'h5A && !m_running;
        go_p = mk && sc == 8'h4D && m_running;
        go_r = mk && sc == 8'h2D;
        go_m = mk && sc == 8'h3A && !m_running;
        m_load = go_enter;
        m_toggle = mk && sc == 8'h29 && m_manual;
        dx = mv == 8'h6B ? -1 : mv == 8'h74 ? 1 : 0;
        dy = mv == 8'h75 ? -1 : mv == 8'h72 ? 1 : 0;
        if (go_enter) begin
            m_file = m_entry;
            m_x0 = 32; m_y0 = 24; m_x1 = 32; m_y1 = 24;
        end else begin
            m_x0 = step(m_x0, dx, 63, 0); m_y0 = step(m_y0, dy, 47, 0);
            m_x1 = step(m_x1, dx, 63, 1); m_y1 = step(m_y1, dy, 47, 1);
        end
        if (go_enter || go_p || go_r) begin
            m_cmd = go_enter ? 1 : go_p ? 2 : 3;
            m_cmd_t = cyc;
        end
        if (go_enter) begin m_running = 1; m_manual = 0; end
        if (go_p || go_r) m_running = 0;
        if (go_r) m_manual = 0;
        if (go_m) m_manual = !m_manual;
        d = digit_val(sc);
        if (go_r) m_entry = 0;
        else if (mk && d >= 0) m_entry = (m_entry * 16 + d) % 4096;
        else if (mk && sc == 8'h66) m_entry = m_entry / 16;
        if (new_arrow) begin m_held = arr; m_hold_t = cyc; end
        else if (stop) m_held = 8'h00;
        if (v) begin
            if (sc == 8'hE0 && !m_ext && !m_brk) m_ext = 1;
            else if (sc == 8'hF0 && !m_brk) m_brk = 1;
            else begin m_ext = 0; m_brk = 0; end
        end
    endtask

    task automatic compare_all();
        chk("start", a_start, m_cmd == 1 && cyc - m_cmd_t < 4);
        chk("pause", a_pause, m_cmd == 2 && cyc - m_cmd_t < 4);
        chk("clear", a_clear, m_cmd == 3 && cyc - m_cmd_t < 4);
        chk("running", a_running, m_running);
        chk("manual", a_manual, m_manual);
        chk("file_id", a_file, m_file);
        chk("file_id_load", a_load, m_load);
        chk("entry_bcd", a_entry, m_entry);
        chk("toggle", a_toggle, m_toggle);
        chk("clamp_x", a_x, m_x0);
        chk("clamp_y", a_y, m_y0);
        chk("clamp_pos", a_pos, m_y0 * 64 + m_x0);
        chk("wrap_x", b_x, m_x1);
        chk("wrap_y", b_y, m_y1);
        chk("wrap_pos", b_pos, m_y1 * 64 + m_x1);
    endtask

    task automatic cycle(input bit v, input logic [7:0] sc);
        kb.scancode_valid = v;
        kb.scancode = sc;
        model_step(v, sc);
        @(negedge clk_in);
        kb.scancode_valid = 1'b0;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        kb.scancode_valid = 1'b0;
        model_reset();
        @(negedge clk_in);
        reset = 1'b0;
        compare_all();
    endtask

    task automatic press_up();
        cycle(1, 8'hE0); cycle(1, 8'h75); cycle(1, 8'hE0); cycle(1, 8'hF0); cycle(1, 8'h75);
    endtask

    logic [7:0] pool [30] = '{8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'h75, 8'h75, 8'h72,
                              8'h72, 8'h6B, 8'h6B, 8'h74, 8'h74, 8'h45, 8'h16, 8'h1E, 8'h26, 8'h5A,
                              8'h5A, 8'h66, 8'h4D, 8'h4D, 8'h2D, 8'h3A, 8'h3A, 8'h29, 8'h1C, 8'h3E};
    int cnt_a, cnt_b;

    initial begin
        n_run = 0; n_fail = 0; cyc = 0; m_hold_t = 0; m_cmd_t = 0;
        reset = 1'b1;
        kb.scancode_valid = 1'b0;
        kb.scancode = 8'h00;
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        compare_all();
        chk("reset_pos", a_pos, 24 * 64 + 32);
        // Typed id commit and start pulse length
        cycle(1, 8'h16); cycle(1, 8'h1E); cycle(1, 8'h26); cycle(1, 8'h25);
        chk("entry_typed", a_entry, 12'h234);
        cycle(1, 8'h5A);
        chk("id_commit", a_file, 12'h234);
        chk("run_on_enter", a_running, 1);
        cnt_a = a_start; cnt_b = a_load;
        repeat (7) begin cycle(0, 0); cnt_a += a_start; cnt_b += a_load; end
        chk("start_len", cnt_a, 4);
        chk("load_len", cnt_b, 1);
        // Pause only while running
        cycle(1, 8'h4D);
        cnt_a = a_pause;
        repeat (7) begin cycle(0, 0); cnt_a += a_pause; end
        chk("pause_len", cnt_a, 4);
        chk("run_off_pause", a_running, 0);
        cycle(1, 8'h4D);
        cnt_a = a_pause;
        repeat (5) begin cycle(0, 0); cnt_a += a_pause; end
        chk("pause_ignored", cnt_a, 0);
        // M ignored while running, R clears everything
        cycle(1, 8'h5A); cycle(1, 8'h3A);
        chk("m_while_running", a_manual, 0);
        cycle(1, 8'h2D);
        cnt_a = a_clear;
        repeat (7) begin cycle(0, 0); cnt_a += a_clear; end
        chk("clear_len", cnt_a, 4);
        chk("clear_entry", a_entry, 0);
        chk("clear_running", a_running, 0);
        // Edge behaviour: clamp vs wrap at the top row
        cycle(1, 8'h3A);
        chk("manual_on", a_manual, 1);
        repeat (24) press_up();
        chk("top_row", a_y, 0);
        press_up();
        chk("clamp_top", a_y, 0);
        chk("wrap_top", b_y, 47);
        // Held right arrow auto-repeat, typematic make ignored, break stops it
        cycle(1, 8'hE0); cycle(1, 8'h74);
        chk("hold_first", a_x, 33);
        for (int k = 1; k <= 40; k++) begin
            if (k == 31) cycle(1, 8'hE0);
            else if (k == 32) cycle(1, 8'h74);
            else cycle(0, 0);
            if (k == 16) chk("rep_16", a_x, 34);
            if (k == 20) chk("rep_20", a_x, 35);
            if (k == 24) chk("rep_24", a_x, 36);
            if (k == 28) chk("rep_28", a_x, 37);
            if (k == 32) chk("rep_typematic", a_x, 38);
            if (k == 36) chk("rep_36", a_x, 39);
        end
        cycle(1, 8'hE0); cycle(1, 8'hF0); cycle(1, 8'h74);
        repeat (20) cycle(0, 0);
        chk("rep_stopped", a_x, 40);
        // Reset after a lone E0 drops the prefix
        cycle(1, 8'hE0);
        do_reset();
        cycle(1, 8'h3A); cycle(1, 8'h75);
        chk("prefix_drop_x", a_x, 32);
        chk("prefix_drop_y", a_y, 24);
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 2) do_reset();
            else if (r < 14) repeat (20) cycle(0, 0);
            else if (r < 450) cycle(0, 0);
            else cycle(1, pool[$urandom_range(0, 29)]);
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
